nibble_serial_adder_ctrl: RTL and testbench

//   Sequences one 4-bit carry-lookahead adder slice over a WIDTH-bit operand pair,
//   one nibble per clock, LSB nibble first.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 8 +
 rtl/nibble_serial_adder_ctrl_cla.sv | 23 ++
 rtl/nibble_serial_adder_ctrl.sv | 94 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// adder_pkg: shared FSM state type, slice width and nibble-count helper
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIB_W = 4;
  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// carry_lookahead_adder_4bit: 4-bit carry-lookahead slice with carry out and signed overflow
module carry_lookahead_adder_4bit (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       v
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = in0 & in1;
  assign p = in0 ^ in1;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign v    = c[4] ^ c[3];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: add/subtract a WIDTH-bit pair one nibble per clock through a single slice
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int NIBS = nibbles(WIDTH);
  localparam int CW   = $clog2(NIBS);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [NIB_W-1:0] s_in0, s_in1, s_sum;
  logic             s_cout, s_v, last, accept, run;
  assign last   = cnt_q == CW'(NIBS - 1);
  assign accept = state_q == IDLE && start_i;
  assign run    = state_q == RUN;
  assign s_in0  = a_q[cnt_q*NIB_W +: NIB_W];
  assign s_in1  = b_q[cnt_q*NIB_W +: NIB_W];
  carry_lookahead_adder_4bit u_slice (
    .in0  (s_in0),
    .in1  (s_in1),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .v    (s_v)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // next state: one RUN cycle per nibble, then a single DONE cycle
  always_comb begin
    state_d = state_q == IDLE ? (start_i ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // handshake outputs decoded from state
  always_comb begin
    busy_o = state_q != IDLE;
    done_o = state_q == DONE;
  end
  // datapath next state: latch operands on accept, write one result nibble per RUN cycle
  always_comb begin
    a_d     = accept ? a_i : a_q;
    b_d     = accept ? b_i ^ {WIDTH{sub_i}} : b_q;
    carry_d = accept ? sub_i : run ? s_cout : carry_q;
    cnt_d   = accept ? '0 : (run && !last) ? cnt_q + 1'b1 : cnt_q;
    res_d   = res_q;
    if (run) res_d[cnt_q*NIB_W +: NIB_W] = s_sum;
    cout_d  = (run && last) ? s_cout : cout_q;
    ovf_d   = (run && last) ? s_v : ovf_q;
    zero_d  = (run && last) ? res_d == '0 : zero_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign result_o = res_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;
  assign zero_o   = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed vectors with a done-driven scoreboard
module tb_nibble_serial_adder_ctrl;
  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        sub_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        busy_o, done_o, cout_o, ovf_o, zero_o;
  logic [15:0] result_o;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  exp_t        q[$];
  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .sub_i    (sub_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .cout_o   (cout_o),
    .ovf_o    (ovf_o),
    .zero_o   (zero_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {16'd0, result_o}, {16'd0, e.res});
        chk("cout", {31'd0, cout_o}, {31'd0, e.cout});
        chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
        chk("zero", {31'd0, zero_o}, {31'd0, e.zero});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] r, input logic c, input logic v, input logic z);
    @(negedge clk);
    start_i = 1'b1; a_i = a; b_i = b; sub_i = s;
    q.push_back('{res: r, cout: c, ovf: v, zero: z, cyc: cyc + 5});
    @(negedge clk);
    start_i = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom); sub_i = ~s;
    chk("busy_c1", {31'd0, busy_o}, 32'd1);
    repeat (4) @(negedge clk);
    chk("busy_c5", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    chk("busy_c6", {31'd0, busy_o}, 32'd0);
    chk("result_held", {16'd0, result_o}, {16'd0, r});
  endtask
  initial begin
    int dc;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", {16'd0, result_o}, 32'd0);
    chk("rst_flags", {29'd0, cout_o, ovf_o, zero_o}, 32'd0);
    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(16'h5000, 16'h3000, 1'b1, 16'h2000, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    // start held high through an op: only the start seen back in IDLE is taken
    @(negedge clk);
    start_i = 1'b1; a_i = 16'h0F0F; b_i = 16'h00F1; sub_i = 1'b0;
    q.push_back('{res: 16'h1000, cout: 1'b0, ovf: 1'b0, zero: 1'b0, cyc: cyc + 5});
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      a_i = 16'($urandom); b_i = 16'($urandom); sub_i = 1'($urandom);
    end
    @(negedge clk);
    a_i = 16'hAAAA; b_i = 16'h5555; sub_i = 1'b0;
    chk("idle_before_reissue", {31'd0, busy_o}, 32'd0);
    q.push_back('{res: 16'hFFFF, cout: 1'b0, ovf: 1'b0, zero: 1'b0, cyc: cyc + 5});
    @(negedge clk);
    start_i = 1'b0;
    repeat (6) @(negedge clk);
    // reset two cycles into an op aborts it without a done pulse
    @(negedge clk);
    start_i = 1'b1; a_i = 16'h1234; b_i = 16'h4321; sub_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_result", {16'd0, result_o}, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
